password_controller: RTL
========================

Name: password_controller

Overview:
- Second login stage, directly downstream of the user-ID controller.
- Consumes MatchedID, InternalID and Guest from that controller and collects a 4-digit password from the keypad.
- Fetches the stored password from the password ROM at base address InternalID and grants access on a match.
- After MAX_ATTEMPTS failures it pulses LogOut back to the user-ID controller, forcing re-entry of the user ID.

Parameters:
- ROM_LATENCY, 2, clock cycles from rom_addr update to valid rom_q.
- MAX_ATTEMPTS, 3, wrong passwords allowed before forced logout; legal range 1..3.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset; asynchronous, active-low.
- Game_Enter  in  1  keypad enter; single-cycle pulse, already debounced.
- User_digit  in  4  digit value, valid while Game_Enter=1.
- MatchedID  in  1  level from the ID controller; user ID accepted.
- InternalID  in  5  ROM base address of the matched user; stable while MatchedID=1.
- Guest  in  1  guest account; skips password entry.
- UserLogOut  in  1  user logout request; single-cycle pulse.
- rom_q  in  4  password ROM data.
- rom_addr  out  5  password ROM address, registered.
- Authorized  out  1  level; password accepted or guest.
- LogOut  out  1  one-cycle pulse to the ID controller.
- AttemptsLeft  out  2  remaining password tries.

Behaviour:
- Reset (async, rst=0) values:
  - Authorized=0, LogOut=0, rom_addr=0, AttemptsLeft=MAX_ATTEMPTS.
  - Digit count, entered-password register (16b) and ROM-password register (16b) = 0.
  - State=IDLE.
- States: IDLE, ENTRY, FETCH, WAIT (ROM_LATENCY cycles), CATCH, COMPARE, GRANTED, CLEAR.
- IDLE:
  - MatchedID=1 & Guest=1 -> GRANTED; Authorized=1 on the next edge.
  - MatchedID=1 & Guest=0 -> ENTRY.
  - Game_Enter is ignored.
- ENTRY:
  - On each Game_Enter: entered <= {entered[11:0], User_digit}; digit count increments.
  - The 4th digit clears the count, sets ROM index=0 and goes to FETCH.
- FETCH: rom_addr <= InternalID + index (5-bit, wraps mod 32) -> WAIT.
- WAIT: holds exactly ROM_LATENCY cycles -> CATCH.
- CATCH:
  - rompw <= {rompw[11:0], rom_q}.
  - index<3 -> index+1, FETCH; else -> COMPARE.
- COMPARE:
  - entered==rompw -> GRANTED, Authorized=1.
  - Mismatch with AttemptsLeft>1 -> AttemptsLeft-1, clear entered and rompw, go to ENTRY.
  - Mismatch with AttemptsLeft==1 -> AttemptsLeft=0, LogOut=1 for one cycle, go to CLEAR.
- GRANTED:
  - Authorized held at 1.
  - UserLogOut=1 -> LogOut=1 for one cycle, Authorized=0, go to CLEAR.
- CLEAR:
  - Waits for MatchedID=0.
  - Then resets AttemptsLeft=MAX_ATTEMPTS, clears registers, goes to IDLE.
  - Prevents re-arming on a stale MatchedID.
- Latency: Authorized rises 4*(ROM_LATENCY+2)+1 edges after the edge capturing the 4th digit (17 at default).
- Game_Enter during FETCH/WAIT/CATCH/COMPARE/GRANTED/CLEAR is ignored; the digit is lost, not queued.
- MatchedID falls in any state other than IDLE/CLEAR:
  - Abort to IDLE next edge; Authorized=0; registers cleared; AttemptsLeft=MAX_ATTEMPTS.
  - No LogOut pulse.
- UserLogOut in ENTRY..COMPARE: LogOut pulse, go to CLEAR; partial digits discarded.
- UserLogOut and MatchedID fall on the same edge: MatchedID fall has priority; no pulse.
- Password 16'h0000 is a legal password; only the Guest input bypasses entry.
- rst asserted mid-fetch: all outputs return to reset values immediately, independent of clk.

Test Plan:
- Correct password:
  - Stimulus: ROM[4..7]=1,2,3,4; MatchedID=1, InternalID=4, Guest=0; enter 1,2,3,4.
  - Response: rom_addr steps 4,5,6,7; Authorized=1 exactly 17 edges after the 4th digit; AttemptsLeft=3; LogOut stays 0.
- Lockout:
  - Stimulus: same ROM; enter 1,2,3,5 three times.
  - Response: AttemptsLeft goes 3->2->1->0; one LogOut pulse after the third COMPARE; Authorized stays 0; holds in CLEAR until MatchedID=0, then AttemptsLeft=3.
- Guest:
  - Stimulus: MatchedID=1, Guest=1.
  - Response: Authorized=1 one edge later; rom_addr stays 0; keypad presses have no effect.
- Logout and wrap:
  - Stimulus: after authorizing InternalID=30 with ROM[30,31,0,1]=9,8,7,6, pulse UserLogOut.
  - Response: addresses wrap 30,31,0,1; LogOut pulses once; Authorized=0 on the same edge.
- Ignored keypad and abort:
  - Stimulus: Game_Enter pulses during WAIT; then drop MatchedID mid-ENTRY after 2 digits.
  - Response: extra digits are ignored and the compare result is unchanged; after the drop, IDLE next edge with no LogOut; fresh entry needs 4 digits.
- Async reset:
  - Stimulus: assert rst low between clock edges during CATCH.
  - Response: Authorized=0, LogOut=0, rom_addr=0, AttemptsLeft=3 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/password_controller.sv
// Password stage of the login flow: collects four keypad digits, reads the
// stored password for the matched user from a latency-pipelined ROM and
// grants access on a match. Repeated failures force a logout back to the
// user-ID controller.
module password_controller #(
  parameter int ROM_LATENCY  = 2,
  parameter int MAX_ATTEMPTS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Game_Enter,
  input  logic [3:0] User_digit,
  input  logic       MatchedID,
  input  logic [4:0] InternalID,
  input  logic       Guest,
  input  logic       UserLogOut,
  input  logic [3:0] rom_q,
  output logic [4:0] rom_addr,
  output logic       Authorized,
  output logic       LogOut,
  output logic [1:0] AttemptsLeft
);

  localparam int              WCW   = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [WCW-1:0]  WLAST = WCW'(ROM_LATENCY - 1);
  localparam logic [1:0]      MAX_A = 2'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_FETCH, S_WAIT, S_CATCH, S_COMPARE, S_GRANTED, S_CLEAR
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;        // digits collected so far
  logic [1:0]     idx_q, idx_d;        // ROM nibble being fetched
  logic [WCW-1:0] wcnt_q, wcnt_d;      // ROM latency countdown
  logic [15:0]    entered_q, entered_d;
  logic [15:0]    rompw_q, rompw_d;
  logic [4:0]     addr_q, addr_d;
  logic           auth_q, auth_d;
  logic           logout_q, logout_d;
  logic [1:0]     att_q, att_d;

  assign rom_addr     = addr_q;
  assign Authorized   = auth_q;
  assign LogOut       = logout_q;
  assign AttemptsLeft = att_q;

  // State and datapath registers; reset lands every output at its idle value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wcnt_q    <= '0;
      entered_q <= '0;
      rompw_q   <= '0;
      addr_q    <= '0;
      auth_q    <= 1'b0;
      logout_q  <= 1'b0;
      att_q     <= MAX_A;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      entered_q <= entered_d;
      rompw_q   <= rompw_d;
      addr_q    <= addr_d;
      auth_q    <= auth_d;
      logout_q  <= logout_d;
      att_q     <= att_d;
    end
  end

  // Next-state logic: normal flow first, then user logout, then the
  // MatchedID-drop abort which outranks everything (and never pulses LogOut).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    entered_d = entered_q;
    rompw_d   = rompw_q;
    addr_d    = addr_q;
    auth_d    = auth_q;
    logout_d  = 1'b0;
    att_d     = att_q;

    case (state_q)
      S_IDLE: begin
        if (MatchedID) begin
          if (Guest) begin
            state_d = S_GRANTED;
            auth_d  = 1'b1;
          end else begin
            state_d = S_ENTRY;
          end
        end
      end
      S_ENTRY: begin
        if (Game_Enter) begin
          entered_d = {entered_q[11:0], User_digit};
          if (cnt_q == 2'd3) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_FETCH: begin
        addr_d  = InternalID + {3'b000, idx_q};
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == WLAST) state_d = S_CATCH;
        else                 wcnt_d  = wcnt_q + 1'b1;
      end
      S_CATCH: begin
        rompw_d = {rompw_q[11:0], rom_q};
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          state_d = S_FETCH;
        end else begin
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (entered_q == rompw_q) begin
          state_d = S_GRANTED;
          auth_d  = 1'b1;
        end else if (att_q > 2'd1) begin
          att_d     = att_q - 2'd1;
          entered_d = '0;
          rompw_d   = '0;
          state_d   = S_ENTRY;
        end else begin
          att_d    = '0;
          logout_d = 1'b1;
          state_d  = S_CLEAR;
        end
      end
      S_GRANTED: begin
        if (UserLogOut) begin
          logout_d = 1'b1;
          auth_d   = 1'b0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // Hold until the ID controller drops MatchedID so a stale match
        // cannot immediately re-arm the password stage.
        if (!MatchedID) begin
          att_d     = MAX_A;
          cnt_d     = '0;
          idx_d     = '0;
          entered_d = '0;
          rompw_d   = '0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // User logout while the password is still being entered or checked.
    if (UserLogOut && (state_q inside {S_ENTRY, S_FETCH, S_WAIT, S_CATCH, S_COMPARE})) begin
      logout_d  = 1'b1;
      auth_d    = 1'b0;
      att_d     = att_q;
      cnt_d     = '0;
      idx_d     = '0;
      entered_d = '0;
      rompw_d   = '0;
      state_d   = S_CLEAR;
    end

    // Losing the user ID aborts silently back to IDLE.
    if (!MatchedID && !(state_q inside {S_IDLE, S_CLEAR})) begin
      logout_d  = 1'b0;
      auth_d    = 1'b0;
      att_d     = MAX_A;
      cnt_d     = '0;
      idx_d     = '0;
      wcnt_d    = '0;
      entered_d = '0;
      rompw_d   = '0;
      state_d   = S_IDLE;
    end
  end

endmodule
